// File: rtl/regs_pkg.sv
// Shared widths, constants and write-port identifiers for the register file.
// Build option REGS_BYPASS_EN enables write-first forwarding on read ports.
package regs_pkg;

    localparam int REGS_DATA_W = 32;
    localparam int REGS_ADDR_W = 5;
    localparam int REG_ZERO    = 0;
    localparam int DBG_BASE    = 16;
    localparam int NWP         = 2;

    // Write-back ports in ascending priority order: the load result is younger.
    typedef enum logic {
        WP_ALU  = 1'b0,
        WP_LOAD = 1'b1
    } wport_e;

endpackage

// File: rtl/regs_if.sv
// Bus bundle between the pipeline (master) and the register file (slave).
// Build option REGS_BYPASS_EN does not change this bundle.
interface regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);

    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;

    logic                  w0_we;
    logic [ADDR_W-1:0]     w0_addr;
    logic [DATA_W-1:0]     w0_data;
    logic                  w1_we;
    logic [ADDR_W-1:0]     w1_addr;
    logic [DATA_W-1:0]     w1_data;

    logic                  iss_we;
    logic [ADDR_W-1:0]     iss_addr;

    logic [ADDR_W-1:0]     dbg_addr;
    logic [DATA_W-1:0]     dbg_data;
    logic                  busy_any;

    modport master (
        output rd_addr,
        output w0_we, w0_addr, w0_data,
        output w1_we, w1_addr, w1_data,
        output iss_we, iss_addr,
        output dbg_addr,
        input  rd_data, rd_busy, dbg_data, busy_any
    );

    modport slave (
        input  rd_addr,
        input  w0_we, w0_addr, w0_data,
        input  w1_we, w1_addr, w1_data,
        input  iss_we, iss_addr,
        input  dbg_addr,
        output rd_data, rd_busy, dbg_data, busy_any
    );

endinterface

// File: rtl/regs_rdport.sv
// One combinational read port: storage mux, r0 check and busy lookup.
// With REGS_BYPASS_EN, same-cycle committing writes are forwarded.
module regs_rdport
    import regs_pkg::*;
#(
    parameter int DATA_W = REGS_DATA_W,
    parameter int ADDR_W = REGS_ADDR_W,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic [ADDR_W-1:0]           addr_i,
    input  logic [DATA_W-1:0]           regs_i [NREG],
    input  logic [NREG-1:0]             busy_i,
`ifdef REGS_BYPASS_EN
    input  logic [NWP-1:0]              wc_i,
    input  logic [NWP-1:0][ADDR_W-1:0]  wa_i,
    input  logic [NWP-1:0][DATA_W-1:0]  wd_i,
`endif
    output logic [DATA_W-1:0]           data_o,
    output logic                        busy_o
);

    logic zero;
    assign zero = (addr_i == ADDR_W'(REG_ZERO));

`ifdef REGS_BYPASS_EN
    logic [NWP-1:0] hit;

    // wc_i already excludes r0, so a hit never forwards into r0.
    for (genvar p = 0; p < NWP; p++) begin : g_hit
        assign hit[p] = wc_i[p] && (wa_i[p] == addr_i);
    end

    always_comb begin
        data_o = zero ? '0 : regs_i[addr_i];
        if (hit[WP_LOAD]) begin
            data_o = wd_i[WP_LOAD];
        end else if (hit[WP_ALU]) begin
            data_o = wd_i[WP_ALU];
        end
    end

    assign busy_o = !zero && busy_i[addr_i] && !(|hit);
`else
    assign data_o = zero ? '0 : regs_i[addr_i];
    assign busy_o = !zero && busy_i[addr_i];
`endif

endmodule

// File: rtl/regs_sb.sv
// Register file with per-register busy scoreboard, two write-back ports.
// Build option REGS_BYPASS_EN: write-first forwarding on every read port.
module regs_sb
    import regs_pkg::*;
#(
    parameter int DATA_W = REGS_DATA_W,
    parameter int ADDR_W = REGS_ADDR_W,
    parameter int NRD    = 2
) (
    input  logic  clk,
    input  logic  rst,
    regs_if.slave bus
);

    localparam int NREG = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic [NWP-1:0]             wc;
    logic [NWP-1:0][ADDR_W-1:0] wa;
    logic [NWP-1:0][DATA_W-1:0] wd;

    assign wa[WP_ALU]  = bus.w0_addr;
    assign wd[WP_ALU]  = bus.w0_data;
    assign wc[WP_ALU]  = bus.w0_we && (bus.w0_addr != ZA);
    assign wa[WP_LOAD] = bus.w1_addr;
    assign wd[WP_LOAD] = bus.w1_data;
    assign wc[WP_LOAD] = bus.w1_we && (bus.w1_addr != ZA);

    // Ports applied in priority order; a new issue overrides any clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < NWP; p++) begin
            if (wc[p]) begin
                regs_d[wa[p]] = wd[p];
                busy_d[wa[p]] = 1'b0;
            end
        end
        if (bus.iss_we && (bus.iss_addr != ZA)) begin
            busy_d[bus.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regs_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NREG   (NREG)
        ) u_rd (
            .addr_i (bus.rd_addr[k*ADDR_W +: ADDR_W]),
            .regs_i (regs_q),
            .busy_i (busy_q),
`ifdef REGS_BYPASS_EN
            .wc_i   (wc),
            .wa_i   (wa),
            .wd_i   (wd),
`endif
            .data_o (rd_data[k*DATA_W +: DATA_W]),
            .busy_o (rd_busy[k])
        );
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.dbg_data = (bus.dbg_addr == ZA) ? '0 : regs_q[bus.dbg_addr];
    assign bus.busy_any = |busy_q;

endmodule

// File: tb/tb_regs_sb.sv
// Self-checking bench for regs_sb: directed tests plus a random sweep.
// Expectations follow REGS_BYPASS_EN when the bench is built with it.
module tb_regs_sb;
    import regs_pkg::*;

`ifdef REGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regs_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) b0 ();
    regs_if #(.DATA_W(16), .ADDR_W(4), .NRD(3)) b1 ();

    regs_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2)) u_dut (
        .clk (clk),
        .rst (rst_n),
        .bus (b0.slave)
    );

    regs_sb #(.DATA_W(16), .ADDR_W(4), .NRD(3)) u_sw (
        .clk (clk),
        .rst (rst_n),
        .bus (b1.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;

    task automatic idle0();
        b0.w0_we = 0; b0.w0_addr = 0; b0.w0_data = 0;
        b0.w1_we = 0; b0.w1_addr = 0; b0.w1_data = 0;
        b0.iss_we = 0; b0.iss_addr = 0;
    endtask

    task automatic idle1();
        b1.rd_addr = 0; b1.dbg_addr = 0;
        b1.w0_we = 0; b1.w0_addr = 0; b1.w0_data = 0;
        b1.w1_we = 0; b1.w1_addr = 0; b1.w1_data = 0;
        b1.iss_we = 0; b1.iss_addr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b0.rd_addr = {5'd5, 5'd5};
        b0.dbg_addr = 5'd5;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL reset_rd got=%h exp=%h", b0.rd_data[31:0], e);
        end
        checks++; e = exp_q.pop_front();
        if (32'(b0.busy_any) !== e) begin
            errors++; $display("FAIL reset_busy_any got=%h exp=%h", b0.busy_any, e);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        b0.w0_we = 1; b0.w0_addr = 5; b0.w0_data = 32'hDEADBEEF;
        b0.iss_we = 1; b0.iss_addr = 6;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h1);
        @(negedge clk) idle0();
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL wr_r5 got=%h exp=%h", b0.rd_data[31:0], e);
        end
        checks++; e = exp_q.pop_front();
        if (32'(b0.busy_any) !== e) begin
            errors++; $display("FAIL pre_rst_busy got=%h exp=%h", b0.busy_any, e);
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL async_rst_rd got=%h exp=%h", b0.rd_data[31:0], e);
        end
        checks++; e = exp_q.pop_front();
        if (32'(b0.busy_any) !== e) begin
            errors++; $display("FAIL async_rst_busy got=%h exp=%h", b0.busy_any, e);
        end
        checks++; e = exp_q.pop_front();
        if (b0.dbg_data !== e) begin
            errors++; $display("FAIL async_rst_dbg got=%h exp=%h", b0.dbg_data, e);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_zero();
        @(negedge clk);
        b0.w0_we = 1; b0.w0_addr = 0; b0.w0_data = 32'h12345678;
        b0.iss_we = 1; b0.iss_addr = 0;
        b0.rd_addr = {5'd0, 5'd0};
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL r0_same_cycle got=%h exp=%h", b0.rd_data[31:0], e);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        @(negedge clk) idle0();
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL r0_read got=%h exp=%h", b0.rd_data[31:0], e);
        end
        checks++; e = exp_q.pop_front();
        if (32'(b0.rd_busy[0]) !== e) begin
            errors++; $display("FAIL r0_busy got=%h exp=%h", b0.rd_busy[0], e);
        end
        checks++; e = exp_q.pop_front();
        if (32'(b0.busy_any) !== e) begin
            errors++; $display("FAIL r0_busy_any got=%h exp=%h", b0.busy_any, e);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        b0.w0_we = 1; b0.w0_addr = 7; b0.w0_data = 32'h1111;
        b0.w1_we = 1; b0.w1_addr = 7; b0.w1_data = 32'h2222;
        exp_q.push_back(32'h2222);
        exp_q.push_back(32'h2222);
        @(negedge clk) idle0();
        b0.rd_addr = {5'd7, 5'd0};
        b0.dbg_addr = 7;
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[63:32] !== e) begin
            errors++; $display("FAIL collide_rd got=%h exp=%h", b0.rd_data[63:32], e);
        end
        checks++; e = exp_q.pop_front();
        if (b0.dbg_data !== e) begin
            errors++; $display("FAIL collide_dbg got=%h exp=%h", b0.dbg_data, e);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        b0.iss_we = 1; b0.iss_addr = 9;
        b0.rd_addr = {5'd0, 5'd9};
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(b0.rd_busy[0]) !== e) begin
            errors++; $display("FAIL sb_c0 got=%h exp=%h", b0.rd_busy[0], e);
        end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk) idle0();
            exp_q.push_back(32'h1);
            #1;
            checks++; e = exp_q.pop_front();
            if (32'(b0.rd_busy[0]) !== e) begin
                errors++; $display("FAIL sb_c%0d got=%h exp=%h", c, b0.rd_busy[0], e);
            end
        end
        @(negedge clk);
        b0.w0_we = 1; b0.w0_addr = 9; b0.w0_data = 32'h99;
        exp_q.push_back(BYP ? 32'h0 : 32'h1);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(b0.rd_busy[0]) !== e) begin
            errors++; $display("FAIL sb_c3_mask got=%h exp=%h", b0.rd_busy[0], e);
        end
        @(negedge clk) idle0();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(b0.rd_busy[0]) !== e) begin
            errors++; $display("FAIL sb_c4 got=%h exp=%h", b0.rd_busy[0], e);
        end
        checks++; e = exp_q.pop_front();
        if (32'(b0.busy_any) !== e) begin
            errors++; $display("FAIL sb_c4_any got=%h exp=%h", b0.busy_any, e);
        end
        b0.iss_we = 1; b0.iss_addr = 9;
        b0.w0_we = 1; b0.w0_addr = 9; b0.w0_data = 32'hAA;
        exp_q.push_back(32'h1);
        @(negedge clk) idle0();
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(b0.rd_busy[0]) !== e) begin
            errors++; $display("FAIL sb_set_wins got=%h exp=%h", b0.rd_busy[0], e);
        end
        b0.w1_we = 1; b0.w1_addr = 9; b0.w1_data = 32'hBB;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hBB);
        @(negedge clk) idle0();
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(b0.rd_busy[0]) !== e) begin
            errors++; $display("FAIL sb_w1_clear got=%h exp=%h", b0.rd_busy[0], e);
        end
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL sb_w1_data got=%h exp=%h", b0.rd_data[31:0], e);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        b0.w0_we = 1; b0.w0_addr = 3; b0.w0_data = 32'h0BADC0DE;
        @(negedge clk) idle0();
        b0.w1_we = 1; b0.w1_addr = 3; b0.w1_data = 32'hCAFEF00D;
        b0.w0_we = 1; b0.w0_addr = 3; b0.w0_data = 32'h55555555;
        b0.rd_addr = {5'd3, 5'd3};
        b0.dbg_addr = 3;
        exp_q.push_back(BYP ? 32'hCAFEF00D : 32'h0BADC0DE);
        exp_q.push_back(32'h0BADC0DE);
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[31:0] !== e) begin
            errors++; $display("FAIL byp_same got=%h exp=%h", b0.rd_data[31:0], e);
        end
        checks++; e = exp_q.pop_front();
        if (b0.dbg_data !== e) begin
            errors++; $display("FAIL byp_dbg_old got=%h exp=%h", b0.dbg_data, e);
        end
        @(negedge clk) idle0();
        exp_q.push_back(32'hCAFEF00D);
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.rd_data[63:32] !== e) begin
            errors++; $display("FAIL byp_next got=%h exp=%h", b0.rd_data[63:32], e);
        end
    endtask

    task automatic test_dbg();
        @(negedge clk);
        b0.w0_we = 1; b0.w0_addr = 5'(DBG_BASE); b0.w0_data = 32'hD00D0016;
        b0.dbg_addr = 5'(DBG_BASE);
        exp_q.push_back(32'hD00D0016);
        @(negedge clk) idle0();
        #1;
        checks++; e = exp_q.pop_front();
        if (b0.dbg_data !== e) begin
            errors++; $display("FAIL dbg_base got=%h exp=%h", b0.dbg_data, e);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] m [16];
        logic [15:0] mb;
        logic [3:0]  ra [3];
        logic [3:0]  a0, a1, ai, da;
        logic [15:0] d0, d1, ev;
        logic        we0, we1, wi, h0, h1, eb;
        for (int i = 0; i < 16; i++) m[i] = '0;
        mb = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            we0 = 1'($urandom % 2);
            we1 = 1'($urandom % 2);
            wi  = ($urandom % 3) == 0;
            a0  = 4'($urandom);
            a1  = ($urandom % 4 == 0) ? a0 : 4'($urandom);
            ai  = 4'($urandom);
            d0  = 16'($urandom);
            d1  = 16'($urandom);
            ra[0] = ($urandom % 2) ? a1 : 4'($urandom);
            ra[1] = ($urandom % 2) ? a0 : 4'($urandom);
            ra[2] = 4'($urandom);
            da = (c % 4 == 0) ? 4'd8 : 4'($urandom);
            b1.w0_we = we0; b1.w0_addr = a0; b1.w0_data = d0;
            b1.w1_we = we1; b1.w1_addr = a1; b1.w1_data = d1;
            b1.iss_we = wi; b1.iss_addr = ai;
            b1.dbg_addr = da;
            for (int k = 0; k < 3; k++) begin
                b1.rd_addr[k*4 +: 4] = ra[k];
                h0 = we0 && (a0 != 0) && (a0 == ra[k]);
                h1 = we1 && (a1 != 0) && (a1 == ra[k]);
                ev = (ra[k] == 0) ? 16'h0 : m[ra[k]];
                eb = (ra[k] != 0) && mb[ra[k]];
                if (BYP && h1) ev = d1;
                else if (BYP && h0) ev = d0;
                if (BYP && (h0 || h1)) eb = 1'b0;
                exp_q.push_back(32'(ev));
                exp_q.push_back(32'(eb));
            end
            exp_q.push_back(32'((da == 0) ? 16'h0 : m[da]));
            exp_q.push_back(32'(|mb));
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++; e = exp_q.pop_front();
                if (32'(b1.rd_data[k*16 +: 16]) !== e) begin
                    errors++;
                    $display("FAIL sweep_rd%0d c=%0d got=%h exp=%h", k, c, b1.rd_data[k*16 +: 16], e);
                end
                checks++; e = exp_q.pop_front();
                if (32'(b1.rd_busy[k]) !== e) begin
                    errors++;
                    $display("FAIL sweep_busy%0d c=%0d got=%h exp=%h", k, c, b1.rd_busy[k], e);
                end
            end
            checks++; e = exp_q.pop_front();
            if (32'(b1.dbg_data) !== e) begin
                errors++; $display("FAIL sweep_dbg c=%0d got=%h exp=%h", c, b1.dbg_data, e);
            end
            checks++; e = exp_q.pop_front();
            if (32'(b1.busy_any) !== e) begin
                errors++; $display("FAIL sweep_any c=%0d got=%h exp=%h", c, b1.busy_any, e);
            end
            if (we0 && a0 != 0) begin m[a0] = d0; mb[a0] = 1'b0; end
            if (we1 && a1 != 0) begin m[a1] = d1; mb[a1] = 1'b0; end
            if (wi && ai != 0) mb[ai] = 1'b1;
        end
        @(negedge clk) idle1();
        b1.w0_we = 1; b1.w0_addr = 8; b1.w0_data = 16'hA5A5;
        exp_q.push_back(32'hA5A5);
        @(negedge clk) idle1();
        b1.dbg_addr = 8;
        #1;
        checks++; e = exp_q.pop_front();
        if (32'(b1.dbg_data) !== e) begin
            errors++; $display("FAIL sweep_dbg8 got=%h exp=%h", b1.dbg_data, e);
        end
    endtask

    initial begin
        idle0();
        idle1();
        b0.rd_addr = '0;
        b0.dbg_addr = '0;
        test_reset();
        test_zero();
        test_collision();
        test_scoreboard();
        test_bypass();
        test_dbg();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
